// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage bridging EX/MEM to a req/ack data port.
// Stalls the front of the pipe while an access is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  input  logic        MemWriteM,
  input  logic        MemToRegM,
  input  logic        RegWriteM,
  input  logic        PCSrcM,
  input  logic        ByteM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] RD,
  output logic [31:0] ALUOutOut,
  output logic [3:0]  WA3Out,
  output logic        MemToRegOut,
  output logic        RegWriteOut,
  output logic        PCSrcOut,
  output logic        StallM,
  output logic        align_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_TO = TIMEOUT[7:0];

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_cap;
  logic        r_tmo_hit;

  logic        w_access;
  logic        w_load;
  logic        w_ack;
  logic        w_tmo;
  logic        w_misalign;
  logic [7:0]  w_byte;

  assign w_access   = MemWriteM | MemToRegM;
  assign w_load     = MemToRegM & ~MemWriteM;
  assign w_ack      = mem_ack & mem_req;
  assign w_misalign = ~ByteM & (ALUOutM[1:0] != 2'b00);

  // Ack in the final counted cycle wins over the timeout.
  assign w_tmo = (r_state == S_WAIT) & ~mem_ack & (r_cnt <= 8'd1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_access)
          w_next = mem_ack ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack || w_tmo)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_cap       <= 32'd0;
      r_tmo_hit   <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tmo_hit <= w_tmo;
      if (r_state == S_IDLE && w_next == S_WAIT)
        r_cnt <= LP_TO;
      else if (r_state == S_WAIT && r_cnt != 8'd0)
        r_cnt <= r_cnt - 8'd1;
      if (w_ack && w_load)
        r_cap <= mem_rdata;
      if (w_tmo)
        timeout_err <= 1'b1;
      if (mem_req && w_misalign)
        align_err <= 1'b1;
    end
  end

  always_comb begin
    mem_req = 1'b0;
    if (!reset) begin
      if (r_state == S_WAIT)
        mem_req = 1'b1;
      else if (r_state == S_IDLE && w_access)
        mem_req = 1'b1;
    end
  end

  assign StallM    = mem_req;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUOutM[31:2], 2'b00};

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = WriteDataM;
    if (MemWriteM && ByteM) begin
      mem_be    = 4'b0001 << ALUOutM[1:0];
      mem_wdata = {4{WriteDataM[7:0]}};
    end
  end

  always_comb begin
    w_byte = r_cap[7:0];
    unique case (ALUOutM[1:0])
      2'd0: w_byte = r_cap[7:0];
      2'd1: w_byte = r_cap[15:8];
      2'd2: w_byte = r_cap[23:16];
      2'd3: w_byte = r_cap[31:24];
      default: w_byte = r_cap[7:0];
    endcase
  end

  always_comb begin
    RD = 32'd0;
    if (r_state == S_DONE && w_load) begin
      if (r_tmo_hit)
        RD = 32'hDEADBEEF;
      else if (ByteM)
        RD = {24'd0, w_byte};
      else
        RD = r_cap;
    end
  end

  assign ALUOutOut   = ALUOutM;
  assign WA3Out      = WA3M;
  assign MemToRegOut = MemToRegM;
  assign RegWriteOut = ~reset & ~StallM & RegWriteM;
  assign PCSrcOut    = ~reset & ~StallM & PCSrcM;

endmodule
